ag6502_bus_ctrl: RTL and testbench

AG6502_BUS_CTRL -- requirements
Module: ag6502_bus_ctrl

---
 rtl/ag6502_bus_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_ag6502_bus_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ag6502_bus_ctrl.sv
// ag6502_bus_ctrl: address decode, memory wait states, IO handshake with
// timeout, and CPU reset stretching for a 6502-style single-clock bus.
module ag6502_bus_ctrl #(
    parameter int RAM_WAIT   = 0,
    parameter int ROM_WAIT   = 1,
    parameter int IO_TIMEOUT = 15,
    parameter int RST_CYCLES = 4
) (
    input  logic        phi_0,
    input  logic        rst,
    input  logic [15:0] ab,
    input  logic        read,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  db_in,
    output logic        rdy,
    output logic        cpu_rst_n,
    output logic        ram_cs,
    output logic        rom_cs,
    output logic        mem_we,
    input  logic [7:0]  ram_rdata,
    input  logic [7:0]  rom_rdata,
    output logic        io_req,
    output logic        io_we,
    input  logic        io_ack,
    input  logic [7:0]  io_rdata,
    output logic        bus_err
);

    localparam int WMAX = (RAM_WAIT > ROM_WAIT) ? RAM_WAIT : ROM_WAIT;
    localparam int WW   = $clog2(WMAX) + 1;
    localparam int TW   = $clog2(IO_TIMEOUT) + 1;
    localparam int RW   = $clog2(RST_CYCLES) + 1;

    // Wait counters are loaded with W-1 because the start cycle is the first stall.
    localparam logic [WW-1:0] RAM_LD  = WW'((RAM_WAIT > 0) ? RAM_WAIT - 1 : 0);
    localparam logic [WW-1:0] ROM_LD  = WW'((ROM_WAIT > 0) ? ROM_WAIT - 1 : 0);
    localparam logic [RW-1:0] RST_LIM = RW'(RST_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MWAIT  = 2'd1,
        IOWAIT = 2'd2,
        IODONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REG_RAM = 2'd0,
        REG_ROM = 2'd1,
        REG_IO  = 2'd2
    } region_t;

    function automatic region_t decode(input logic [15:0] a);
        if (a[15:8] == 8'hC0) begin
            return REG_IO;
        end else if (a[15:12] == 4'hF) begin
            return REG_ROM;
        end
        return REG_RAM;
    endfunction

    // Counters saturate at their limit instead of wrapping.
    function automatic int sat_inc(input int v, input int lim);
        return (v >= lim) ? lim : v + 1;
    endfunction

    state_t          state_q, state_d;
    region_t         region_q, region_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [RW-1:0]   rcnt_q, rcnt_d;
    logic            cpu_rst_n_q, cpu_rst_n_d;
    logic            bus_err_q, bus_err_d;
    logic [7:0]      iodat_q, iodat_d;
    logic [7:0]      hold_q, hold_d;

    region_t         ab_region;
    region_t         cur_region;
    logic [7:0]      mem_rdata;
    logic            start;
    logic            mem_wait;
    logic            timeout;

    // Write data goes straight from the CPU to the memories and IO devices.
    logic            unused_cpu_dout;
    assign unused_cpu_dout = ^cpu_dout;

    assign cpu_rst_n = cpu_rst_n_q;
    assign bus_err   = bus_err_q;

    // Decode the live address; once an access is in flight the latched region is used.
    always_comb begin
        ab_region  = decode(ab);
        cur_region = (state_q == IDLE) ? ab_region : region_q;
        mem_rdata  = (cur_region == REG_ROM) ? rom_rdata : ram_rdata;
        start      = (state_q == IDLE) && cpu_rst_n_q;
        mem_wait   = (ab_region == REG_ROM) ? (ROM_WAIT > 0) : (RAM_WAIT > 0);
        timeout    = (int'(tcnt_q) + 1 >= IO_TIMEOUT);
    end

    // State register and datapath flops; reset abandons any access in progress.
    always_ff @(posedge phi_0 or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            region_q    <= REG_RAM;
            wcnt_q      <= '0;
            tcnt_q      <= '0;
            rcnt_q      <= '0;
            cpu_rst_n_q <= 1'b0;
            bus_err_q   <= 1'b0;
            iodat_q     <= 8'h00;
            hold_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            region_q    <= region_d;
            wcnt_q      <= wcnt_d;
            tcnt_q      <= tcnt_d;
            rcnt_q      <= rcnt_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            bus_err_q   <= bus_err_d;
            iodat_q     <= iodat_d;
            hold_q      <= hold_d;
        end
    end

    // Next-state logic: only stalled reads leave IDLE, writes are posted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && read) begin
                    if (ab_region == REG_IO) begin
                        state_d = IOWAIT;
                    end else if (mem_wait) begin
                        state_d = MWAIT;
                    end
                end
            end
            MWAIT: begin
                if (wcnt_q == '0) begin
                    state_d = IDLE;
                end
            end
            IOWAIT: begin
                if (io_ack || timeout) begin
                    state_d = IODONE;
                end
            end
            IODONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Counters, latched region, IO result byte and the held read byte.
    always_comb begin
        region_d    = region_q;
        wcnt_d      = wcnt_q;
        tcnt_d      = tcnt_q;
        bus_err_d   = bus_err_q;
        iodat_d     = iodat_q;
        hold_d      = hold_q;
        rcnt_d      = RW'(sat_inc(int'(rcnt_q), RST_CYCLES));
        cpu_rst_n_d = (rcnt_d == RST_LIM);
        case (state_q)
            IDLE: begin
                if (start && read) begin
                    region_d = ab_region;
                    if (ab_region == REG_IO) begin
                        tcnt_d = '0;
                    end else if (mem_wait) begin
                        wcnt_d = (ab_region == REG_ROM) ? ROM_LD : RAM_LD;
                    end else begin
                        hold_d = mem_rdata;
                    end
                end
            end
            MWAIT: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - WW'(1);
                end else begin
                    hold_d = mem_rdata;
                end
            end
            IOWAIT: begin
                tcnt_d = TW'(sat_inc(int'(tcnt_q), IO_TIMEOUT));
                if (io_ack) begin
                    iodat_d = io_rdata;
                end else if (timeout) begin
                    iodat_d   = 8'hFF;
                    bus_err_d = 1'b1;
                end
            end
            IODONE: begin
                hold_d = iodat_q;
            end
            default: begin
                hold_d = hold_q;
            end
        endcase
    end

    // Bus outputs: selects, strobes, ready and the read data mux.
    always_comb begin
        rdy    = 1'b1;
        ram_cs = 1'b0;
        rom_cs = 1'b0;
        mem_we = 1'b0;
        io_req = 1'b0;
        io_we  = 1'b0;
        db_in  = hold_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ram_cs = (ab_region == REG_RAM);
                    rom_cs = (ab_region == REG_ROM);
                    if (!read) begin
                        mem_we = (ab_region != REG_IO);
                        io_req = (ab_region == REG_IO);
                        io_we  = (ab_region == REG_IO);
                    end else if ((ab_region == REG_IO) || mem_wait) begin
                        rdy = 1'b0;
                    end else begin
                        db_in = mem_rdata;
                    end
                end
            end
            MWAIT: begin
                ram_cs = (region_q == REG_RAM);
                rom_cs = (region_q == REG_ROM);
                if (wcnt_q != '0) begin
                    rdy = 1'b0;
                end else begin
                    db_in = mem_rdata;
                end
            end
            IOWAIT: begin
                io_req = 1'b1;
                rdy    = 1'b0;
            end
            IODONE: begin
                db_in = iodat_q;
            end
            default: begin
                rdy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_ag6502_bus_ctrl.sv
// Bench for ag6502_bus_ctrl: a CPU-side driver pushes expected bus-cycle
// outcomes into a scoreboard; a monitor pops them at each completed cycle.
module tb_ag6502_bus_ctrl;

    localparam int RAM_WAIT   = 0;
    localparam int ROM_WAIT   = 1;
    localparam int IO_TIMEOUT = 15;
    localparam int RST_CYCLES = 4;

    logic        phi_0 = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ab = 16'h0000;
    logic        read = 1'b1;
    logic [7:0]  cpu_dout = 8'h00;
    logic [7:0]  ram_rdata = 8'h00;
    logic [7:0]  rom_rdata = 8'h00;
    logic        io_ack = 1'b0;
    logic [7:0]  io_rdata = 8'h00;
    logic [7:0]  db_in;
    logic        rdy, cpu_rst_n, ram_cs, rom_cs, mem_we, io_req, io_we, bus_err;

    ag6502_bus_ctrl #(
        .RAM_WAIT(RAM_WAIT), .ROM_WAIT(ROM_WAIT),
        .IO_TIMEOUT(IO_TIMEOUT), .RST_CYCLES(RST_CYCLES)
    ) dut (
        .phi_0(phi_0), .rst(rst), .ab(ab), .read(read), .cpu_dout(cpu_dout),
        .db_in(db_in), .rdy(rdy), .cpu_rst_n(cpu_rst_n),
        .ram_cs(ram_cs), .rom_cs(rom_cs), .mem_we(mem_we),
        .ram_rdata(ram_rdata), .rom_rdata(rom_rdata),
        .io_req(io_req), .io_we(io_we), .io_ack(io_ack), .io_rdata(io_rdata),
        .bus_err(bus_err)
    );

    always #5 phi_0 = ~phi_0;

    typedef struct {
        bit         rd;
        logic [7:0] data;
        logic [7:0] hold;
        int         stalls;
        int         ioreq;
        bit         iowe;
        bit         memwe;
        bit         ramcs;
        bit         romcs;
        bit         err;
    } exp_t;

    exp_t       sbq[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    int         ack_dly = 0;
    bit         err_m = 1'b0;
    logic [7:0] last_rd = 8'h00;
    int         m_stall = 0;
    int         m_ioreq = 0;
    bit         m_hold_bad = 1'b0;
    bit         m_strb_bad = 1'b0;
    int         dev_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // 0 = RAM, 1 = ROM, 2 = IO, straight from the address map.
    function automatic int region_of(input int a);
        if (a >= 'hC000 && a <= 'hC0FF) return 2;
        if (a >= 'hF000) return 1;
        return 0;
    endfunction

    // IO device: acknowledges a read on the ack_dly-th cycle of io_req (0 = never).
    always @(negedge phi_0) begin
        if (io_req && !io_we) begin
            dev_n++;
            io_ack = (ack_dly != 0) && (dev_n == ack_dly);
        end else begin
            dev_n  = 0;
            io_ack = 1'b0;
        end
    end

    // Monitor: accumulates stall behaviour and checks each completed bus cycle.
    always @(negedge phi_0) begin
        if (!mon_en || !cpu_rst_n) begin
            m_stall = 0; m_ioreq = 0; m_hold_bad = 1'b0; m_strb_bad = 1'b0;
        end else begin
            if (io_req) m_ioreq++;
            if (!rdy) begin
                m_stall++;
                if (sbq.size() > 0 && db_in !== sbq[0].hold) m_hold_bad = 1'b1;
                if (mem_we || io_we) m_strb_bad = 1'b1;
            end else if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow actual=completion required=none");
            end else begin
                mon_e = sbq.pop_front();
                chk("stall_cycles", m_stall, mon_e.stalls);
                chk("io_req_cycles", m_ioreq, mon_e.ioreq);
                chk("io_we", io_we, mon_e.iowe);
                chk("mem_we", mem_we, mon_e.memwe);
                chk("ram_cs", ram_cs, mon_e.ramcs);
                chk("rom_cs", rom_cs, mon_e.romcs);
                chk("bus_err", bus_err, mon_e.err);
                chk("db_in", db_in, mon_e.rd ? mon_e.data : mon_e.hold);
                chk("db_hold_in_stall", m_hold_bad, 0);
                chk("strobe_in_stall", m_strb_bad, 0);
                m_stall = 0; m_ioreq = 0; m_hold_bad = 1'b0; m_strb_bad = 1'b0;
            end
        end
    end

    // One CPU bus cycle; called and returns at 1 time unit after a rising edge.
    task automatic do_txn(input logic [15:0] addr, input bit rd, input logic [7:0] val,
                          input int dly, input bit scr);
        exp_t e;
        int   rg;
        int   n;
        rg        = region_of(int'(addr));
        ab        = addr;
        read      = rd;
        cpu_dout  = val;
        io_rdata  = val;
        ack_dly   = dly;
        ram_rdata = (rg == 1) ? (val ^ 8'hA5) : val;
        rom_rdata = (rg == 1) ? val : (val ^ 8'h5A);
        e.rd    = rd;
        e.hold  = last_rd;
        e.data  = 8'h00;
        e.ramcs = (rg == 0);
        e.romcs = (rg == 1);
        e.memwe = !rd && (rg != 2);
        e.iowe  = !rd && (rg == 2);
        e.ioreq = (!rd && rg == 2) ? 1 : 0;
        e.stalls = 0;
        if (rd) begin
            if (rg == 0) begin
                e.stalls = RAM_WAIT;
                e.data   = val;
            end else if (rg == 1) begin
                e.stalls = ROM_WAIT;
                e.data   = val;
            end else begin
                e.ramcs = 1'b0;
                e.romcs = 1'b0;
                if (dly >= 1 && dly <= IO_TIMEOUT) begin
                    e.stalls = 1 + dly;
                    e.ioreq  = dly;
                    e.data   = val;
                end else begin
                    e.stalls = 1 + IO_TIMEOUT;
                    e.ioreq  = IO_TIMEOUT;
                    e.data   = 8'hFF;
                    err_m    = 1'b1;
                end
            end
            last_rd = e.data;
        end
        e.err = err_m;
        sbq.push_back(e);
        n = 0;
        forever begin
            @(negedge phi_0);
            if (rdy) break;
            n++;
            if (n > 40) begin
                checks++;
                errors++;
                $display("FAIL txn_bound actual=%0d stall cycles required=<=40", n);
                break;
            end
            @(posedge phi_0);
            #1;
            if (scr) ab = 16'($urandom);
        end
        @(posedge phi_0);
        #1;
    endtask

    task automatic reset_stretch();
        rst = 1'b1;
        for (int i = 1; i <= RST_CYCLES; i++) begin
            @(posedge phi_0);
            #1;
            chk("cpu_rst_n_stretch", cpu_rst_n, (i == RST_CYCLES));
            if (i < RST_CYCLES) begin
                chk("strobes_in_stretch", {ram_cs, rom_cs, mem_we, io_req, io_we}, 0);
                chk("rdy_in_stretch", rdy, 1);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] bnd [6];
        logic [15:0] addr;
        bnd = '{16'hBFFF, 16'hC000, 16'hC0FF, 16'hC100, 16'hEFFF, 16'hF000};

        #2 rst = 1'b0;
        ab   = 16'hC010;
        read = 1'b1;
        repeat (3) @(posedge phi_0);
        @(negedge phi_0);
        chk("rst_cpu_rst_n", cpu_rst_n, 0);
        chk("rst_rdy", rdy, 1);
        chk("rst_db_in", db_in, 8'h00);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_strobes", {ram_cs, rom_cs, mem_we, io_req, io_we}, 0);
        reset_stretch();
        mon_en = 1'b1;

        do_txn(16'h1234, 1'b1, 8'h5A, 0, 1'b0);
        do_txn(16'hFFFC, 1'b1, 8'h00, 0, 1'b0);
        do_txn(16'hC010, 1'b1, 8'h7E, 3, 1'b0);
        do_txn(16'hC005, 1'b0, 8'h33, 0, 1'b0);
        do_txn(16'h0200, 1'b0, 8'h44, 0, 1'b0);
        do_txn(16'hF123, 1'b0, 8'h55, 0, 1'b0);
        do_txn(16'hC0FF, 1'b1, 8'h81, 15, 1'b1);
        do_txn(16'hBFFF, 1'b1, 8'h92, 0, 1'b0);
        do_txn(16'hF000, 1'b1, 8'hC3, 0, 1'b1);
        do_txn(16'hC020, 1'b1, 8'h11, 0, 1'b0);
        do_txn(16'hC100, 1'b1, 8'h27, 0, 1'b0);
        do_txn(16'hC000, 1'b1, 8'h6D, 1, 1'b1);

        // Reset asserted in the middle of an IO read.
        mon_en  = 1'b0;
        ab      = 16'hC030;
        read    = 1'b1;
        ack_dly = 0;
        repeat (3) begin
            @(posedge phi_0);
            #1;
        end
        chk("io_req_before_rst", io_req, 1);
        rst = 1'b0;
        #1;
        chk("midrst_io_req", io_req, 0);
        chk("midrst_rdy", rdy, 1);
        chk("midrst_bus_err", bus_err, 0);
        chk("midrst_cpu_rst_n", cpu_rst_n, 0);
        chk("midrst_db_in", db_in, 8'h00);
        repeat (2) begin
            @(posedge phi_0);
            #1;
            chk("midrst_io_req_hold", io_req, 0);
        end
        sbq.delete();
        err_m   = 1'b0;
        last_rd = 8'h00;
        reset_stretch();
        mon_en = 1'b1;

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 4))
                0: addr = 16'hC000 | 16'($urandom_range(0, 255));
                1: addr = 16'hF000 | 16'($urandom_range(0, 4095));
                2: addr = 16'($urandom);
                3: addr = bnd[$urandom_range(0, 5)];
                default: addr = 16'($urandom_range(0, 16'hBFFF));
            endcase
            do_txn(addr, ($urandom_range(0, 2) != 0), 8'($urandom),
                   $urandom_range(0, 18), 1'($urandom_range(0, 1)));
        end

        chk("sb_drain", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
